// File: rtl/iter_shift_unit.sv
// Iterative SLL/SRL/SRA shifter: one bit per cycle, or four bits per cycle when SHIFT_STEP4_EN is defined.
// Latency: n+1 cycles from start to done (n = shamt[SHW-1:0]). Start is ignored while busy; flush aborts.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [1:0]       op_q, op_d;

  // Upper shift-amount bits are sign-extension from the extender and carry no information.
  logic unused_shamt;
  assign unused_shamt = ^shamt[31:SHW];

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       o,
                                                input int unsigned      k);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = v << k;
      OP_SRL:  r = v >> k;
      OP_SRA:  r = WIDTH'($signed(v) >>> k);
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_d  = data_in;
            op_d    = op;
            count_d = (op == OP_RSV) ? '0 : shamt[SHW-1:0];
            if (count_d == '0) begin
              state_d  = DONE;
              result_d = data_in;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
`ifdef SHIFT_STEP4_EN
          if (count_q >= SHW'(4)) begin
            work_d  = shift_by(work_q, op_q, 4);
            count_d = count_q - SHW'(4);
          end else begin
            work_d  = shift_by(work_q, op_q, 1);
            count_d = count_q - SHW'(1);
          end
`else
          work_d  = shift_by(work_q, op_q, 1);
          count_d = count_q - SHW'(1);
`endif
          // Result is captured on the same edge that enters DONE.
          if (count_d == '0) begin
            state_d  = DONE;
            result_d = work_d;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= OP_SLL;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit; expected latencies follow SHIFT_STEP4_EN when defined.
module tb_iter_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  iter_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int n);
`ifdef SHIFT_STEP4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Pulse start, scramble inputs afterwards, then observe 40 cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [31:0] s,
                        output int lat, output int bcyc, output int dcnt,
                        output logic [31:0] res);
    lat = -1; bcyc = 0; dcnt = 0; res = 32'h0;
    op = o; data_in = d; shamt = s; start = 1'b1;
    tick();
    start = 1'b0; op = 2'b01; data_in = 32'hDEAD_BEEF; shamt = 32'hFFFF_FFFF;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        dcnt++;
        if (lat < 0) begin
          lat = k;
          res = result;
        end
      end
      if (busy) bcyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
    #12;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sll();
    int lat, bcyc, dcnt; logic [31:0] res;
    run_op(2'b00, 32'h0000_0001, 32'h0000_0004, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'h0000_0010) begin tests_failed++; $display("FAIL sll_result: got %h want 00000010", res); end
    tests_run++;
    if (lat !== exp_lat(4)) begin tests_failed++; $display("FAIL sll_latency: got %0d want %0d", lat, exp_lat(4)); end
    tests_run++;
    if (bcyc !== exp_lat(4)) begin tests_failed++; $display("FAIL sll_busy_cycles: got %0d want %0d", bcyc, exp_lat(4)); end
    tests_run++;
    if (dcnt !== 1) begin tests_failed++; $display("FAIL sll_done_count: got %0d want 1", dcnt); end
    tests_run++;
    if (result !== 32'h0000_0010) begin tests_failed++; $display("FAIL sll_result_held: got %h want 00000010", result); end
  endtask

  task automatic test_sra();
    int lat, bcyc, dcnt; logic [31:0] res;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sra31_result: got %h want ffffffff", res); end
    tests_run++;
    if (lat !== exp_lat(31)) begin tests_failed++; $display("FAIL sra31_latency: got %0d want %0d", lat, exp_lat(31)); end
    run_op(2'b10, 32'h8000_0000, 32'h0000_0005, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'hFC00_0000) begin tests_failed++; $display("FAIL sra5_result: got %h want fc000000", res); end
    tests_run++;
    if (lat !== exp_lat(5)) begin tests_failed++; $display("FAIL sra5_latency: got %0d want %0d", lat, exp_lat(5)); end
    run_op(2'b10, 32'h4000_00F0, 32'h0000_0004, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'h0400_000F) begin tests_failed++; $display("FAIL sra_pos_result: got %h want 0400000f", res); end
  endtask

  task automatic test_srl_zero();
    int lat, bcyc, dcnt; logic [31:0] res;
    run_op(2'b01, 32'hF000_000F, 32'h0, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'hF000_000F) begin tests_failed++; $display("FAIL srl0_result: got %h want f000000f", res); end
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL srl0_latency: got %0d want 1", lat); end
    run_op(2'b01, 32'hF000_000F, 32'h8, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'h00F0_0000) begin tests_failed++; $display("FAIL srl8_result: got %h want 00f00000", res); end
    tests_run++;
    if (lat !== exp_lat(8)) begin tests_failed++; $display("FAIL srl8_latency: got %0d want %0d", lat, exp_lat(8)); end
  endtask

  task automatic test_start_while_busy();
    int dcnt, lat; logic [31:0] res;
    dcnt = 0; lat = -1; res = 32'h0;
    op = 2'b00; data_in = 32'h0000_0003; shamt = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        start = 1'b1; op = 2'b11; data_in = 32'h1234_5678; shamt = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcnt++;
        if (lat < 0) begin lat = k; res = result; end
      end
      tick();
    end
    tests_run++;
    if (res !== 32'h0000_0C00) begin tests_failed++; $display("FAIL busy_start_result: got %h want 00000c00", res); end
    tests_run++;
    if (dcnt !== 1) begin tests_failed++; $display("FAIL busy_start_done_count: got %0d want 1", dcnt); end
    tests_run++;
    if (lat !== exp_lat(10)) begin tests_failed++; $display("FAIL busy_start_latency: got %0d want %0d", lat, exp_lat(10)); end
  endtask

  task automatic test_reserved();
    int lat, bcyc, dcnt; logic [31:0] res;
    run_op(2'b11, 32'hA5A5_A5A5, 32'h0000_001F, lat, bcyc, dcnt, res);
    tests_run++;
    if (res !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL rsv_result: got %h want a5a5a5a5", res); end
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL rsv_latency: got %0d want 1", lat); end
  endtask

  task automatic test_start_in_done();
    int dcnt;
    dcnt = 0;
    op = 2'b11; data_in = 32'h0000_0011; shamt = 32'd0; start = 1'b1;
    tick();
    data_in = 32'h0000_0022;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) dcnt++;
      tick();
    end
    tests_run++;
    if (dcnt !== 0 || result !== 32'h0000_0011) begin
      tests_failed++;
      $display("FAIL start_in_done: extra dones=%0d result=%h, want 0 00000011", dcnt, result);
    end
  endtask

  task automatic test_flush();
    int dcnt;
    dcnt = 0;
    op = 2'b00; data_in = 32'h0000_0001; shamt = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %b want 0", busy); end
    for (int k = 0; k < 30; k++) begin
      if (done) dcnt++;
      tick();
    end
    tests_run++;
    if (dcnt !== 0) begin tests_failed++; $display("FAIL flush_no_done: got %0d dones want 0", dcnt); end
    tests_run++;
    if (result !== 32'h0000_0011) begin tests_failed++; $display("FAIL flush_result_kept: got %h want 00000011", result); end
  endtask

  task automatic test_reset_mid();
    op = 2'b00; data_in = 32'h0000_0001; shamt = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra();
    test_srl_zero();
    test_start_while_busy();
    test_reserved();
    test_start_in_done();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle shifter that sits directly downstream of the 5-bit shift-amount extender in the execute stage.
- Consumes the 32-bit extended shift amount and a 32-bit operand, then performs SLL/SRL/SRA one bit position per cycle.
- Uses a start/busy/done handshake toward the pipeline control, which stalls while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, 5, number of low shift-amount bits actually used (log2 of WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a shift; sampled only in IDLE.
- flush  input  1  synchronous abort; pipeline flush.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- data_in  input  WIDTH  operand to shift.
- shamt  input  32  extended shift amount; only shamt[SHW-1:0] is used, upper bits ignored (may be all-ones after sign extension).
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result  output  WIDTH  shifted value; held until the next accepted start.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, internal count=0, working register=0.
- States:
  - IDLE: on start=1 and flush=0, latch data_in into the working register, latch op, and load count=shamt[SHW-1:0]. Go to SHIFT if count!=0, else go to DONE. start while busy is ignored, not queued.
  - SHIFT: each cycle, shift the working register by 1 and decrement count. Shift rules:
    - SLL: zero fill from the LSB.
    - SRL: zero fill from the MSB.
    - SRA: replicate bit WIDTH-1.
  - SHIFT exit: when count reaches 1 in the current cycle, the last shift is performed and the next state is DONE.
  - DONE: done=1 for exactly one cycle; result=working register, registered on entry to DONE. Next state is IDLE. start in DONE is ignored.
- Op 11 (reserved): count forced to 0 and result=data_in (pass-through), done after 1 cycle.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(n+1), where n=shamt[4:0]. n=0 gives done one cycle after start; n=31 gives done 32 cycles after start.
- busy: rises the cycle after an accepted start and falls the cycle after done.
- flush=1: in any state, next state is IDLE, done=0, result unchanged. flush has priority over start in the same cycle.
- Reset mid-operation: immediately returns to the reset values; no done pulse is emitted.
- data_in, op and shamt may change freely after the start cycle; the latched copies are used.

Optional Feature:
- Macro: SHIFT_STEP4_EN.
- Defined: in SHIFT, when count>=4 the unit shifts by 4 positions and count decrements by 4; otherwise it shifts by 1 and decrements by 1.
  - Cycles in SHIFT = floor(n/4) + (n mod 4).
  - n=31 gives done 11 cycles after start; n=5 gives done 3 cycles after start.
  - SRA fills the 4 vacated bits with the sign bit.
- Undefined: strictly 1 bit per cycle, latency as stated in Behaviour. The port list is identical in both builds.

Test Plan:
- SLL: data_in=0x0000_0001, shamt=0x0000_0004 -> done 5 cycles after start, result=0x0000_0010. busy high for 5 cycles.
- SRA with sign-extended amount: data_in=0x8000_0000, shamt=0xFFFF_FFFF (ext of 5'b11111) -> n=31, result=0xFFFF_FFFF, done 32 cycles after start (11 with SHIFT_STEP4_EN).
- SRL and zero amount:
  - data_in=0xF000_000F, shamt=0 -> done 1 cycle after start, result=0xF000_000F.
  - Repeat with shamt=8 -> result=0x00F0_0000.
- Start while busy and reserved op:
  - Second start (data_in=0x1234_5678) pulsed mid-SHIFT -> ignored; first result delivered unchanged, exactly one done pulse.
  - op=11 with data_in=0xA5A5_A5A5 -> result=0xA5A5_A5A5 after 1 cycle.
- flush and reset mid-operation:
  - flush asserted 3 cycles into an n=20 shift -> busy=0 next cycle, no done pulse, result keeps its previous value.
  - rst_n pulsed low mid-shift -> busy=0, done=0, result=0 immediately, without waiting for a clock edge.
